mem_stage_dcache: RTL and testbench

- MEM-stage data cache of the 16-bit pipelined core, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU address, store data and memRead/memWrite controls; returns load data to the MEM/WB register.
- Direct-mapped, write-through, no-write-allocate, 16-byte (8-word) blocks; refills from a fixed-latency pipelined main memory.
- Raises a stall that freezes the upstream pipeline registers during a miss.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_arrays.sv | 54 +++++
 rtl/mem_stage_dcache.sv | 155 +++++++++++++++
 tb/tb_mem_stage_dcache.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants, FSM encoding and tag-width helper for the MEM-stage data cache
package dcache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    function automatic int tag_width(input int index_bits);
        return 12 - index_bits;
    endfunction

endpackage

// File: rtl/dcache_arrays.sv
// rtl/dcache_arrays.sv - valid/tag/data storage: async read, sync write, bulk valid clear
module dcache_arrays
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_W      = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [15:0]            rd_word,
    input  logic                   word_we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [15:0]            wr_word,
    input  logic                   tag_we,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   valid_clr_all
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [15:0]      data_q [LINES*BLOCK_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[{rd_index, rd_offset}];

    // A bulk clear wins over a same-cycle line validation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (valid_clr_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
        if (word_we) begin
            data_q[{wr_index, wr_offset}] <= wr_word;
        end
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// rtl/mem_stage_dcache.sv - direct-mapped write-through MEM-stage dcache; DCACHE_PERF_EN adds hit/miss counters
module mem_stage_dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int MEM_LAT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        inv,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int TAG_W = tag_width(INDEX_BITS);

    state_t      state_q;
    logic [3:0]  issue_cnt_q;
    logic [2:0]  recv_cnt_q;
    logic [11:0] base_q;
    logic        inv_pend_q;

    logic [INDEX_BITS-1:0]  idx;
    logic [TAG_W-1:0]       tag;
    logic [OFFSET_BITS-1:0] off;
    logic                   line_valid;
    logic [TAG_W-1:0]       line_tag;
    logic [15:0]            line_word;
    logic                   hit, idle, in_fill, load_miss, load_hit, store_req;
    logic                   fill_req, fill_done, store_hit, valid_clr_all;

    assign idx = addr[4+INDEX_BITS-1:4];
    assign tag = addr[15:4+INDEX_BITS];
    assign off = addr[3:1];

    assign idle      = (state_q == IDLE);
    assign in_fill   = (state_q == FILL);
    assign hit       = line_valid & (line_tag == tag);
    assign store_req = idle & wr_en;
    assign load_hit  = idle & rd_en & ~wr_en & hit;
    assign load_miss = idle & rd_en & ~wr_en & ~hit;
    assign store_hit = store_req & hit;
    assign fill_req  = in_fill & ~issue_cnt_q[3];
    assign fill_done = in_fill & mem_valid & (recv_cnt_q == 3'd7);

    // An invalidate seen during a fill is held until the line lands, then wipes it too.
    assign valid_clr_all = (idle & inv) | (fill_done & (inv_pend_q | inv));

    dcache_arrays #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_arrays (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_index     (idx),
        .rd_offset    (off),
        .rd_valid     (line_valid),
        .rd_tag       (line_tag),
        .rd_word      (line_word),
        .word_we      (store_hit | (in_fill & mem_valid)),
        .wr_index     (in_fill ? base_q[INDEX_BITS-1:0] : idx),
        .wr_offset    (in_fill ? recv_cnt_q : off),
        .wr_word      (in_fill ? mem_rdata : wdata),
        .tag_we       (fill_done),
        .wr_tag       (base_q[11:INDEX_BITS]),
        .valid_clr_all(valid_clr_all)
    );

    // Outputs are forced quiet while reset is asserted, even mid-fill.
    assign stall     = rst_n & (in_fill | load_miss);
    assign mem_en    = rst_n & (store_req | fill_req);
    assign mem_wr    = rst_n & store_req;
    assign mem_addr  = !rst_n   ? 16'h0000 :
                       store_req ? {addr[15:1], addr[0] & 1'b0} :
                       fill_req  ? {base_q, issue_cnt_q[2:0], 1'b0} : 16'h0000;
    assign mem_wdata = (rst_n & store_req) ? wdata : 16'h0000;
    assign rd_data   = (rst_n & load_hit) ? line_word : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= 4'd0;
            recv_cnt_q  <= 3'd0;
            base_q      <= 12'h000;
            inv_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    inv_pend_q <= 1'b0;
                    if (load_miss) begin
                        state_q     <= FILL;
                        base_q      <= addr[15:4];
                        issue_cnt_q <= 4'd0;
                        recv_cnt_q  <= 3'd0;
                    end
                end
                FILL: begin
                    if (fill_req) begin
                        issue_cnt_q <= issue_cnt_q + 4'd1;
                    end
                    if (mem_valid) begin
                        recv_cnt_q <= recv_cnt_q + 3'd1;
                    end
                    if (inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (fill_done) begin
                        state_q     <= IDLE;
                        issue_cnt_q <= 4'd0;
                        recv_cnt_q  <= 3'd0;
                        inv_pend_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else begin
            if (load_hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (load_miss && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb/tb_mem_stage_dcache.sv - directed self-checking bench for mem_stage_dcache
module tb_mem_stage_dcache;

    localparam int MEM_LAT = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd_en;
    logic        wr_en;
    logic        inv;
    logic [15:0] rd_data;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    int checks = 0;
    int errors = 0;

    mem_stage_dcache #(
        .INDEX_BITS(5),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .inv      (inv),
        .rd_data  (rd_data),
        .stall    (stall),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory: word[a] = a ^ A5A5 unless written; fixed-latency read pipeline.
    logic [15:0] wmem [logic [15:0]];
    logic        pv [MEM_LAT];
    logic [15:0] pd [MEM_LAT];

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (wmem.exists(a)) return wmem[a];
        return a ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_wr) wmem[mem_addr] = mem_wdata;
        pv[0] <= mem_en && !mem_wr;
        pd[0] <= model_rd(mem_addr);
        for (int i = 1; i < MEM_LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_valid = pv[MEM_LAT-1];
    assign mem_rdata = pd[MEM_LAT-1];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] exp, input int exp_st,
                           input int exp_req, input int inv_at, input string tag);
        int st, nreq, last_c;
        logic [15:0] base;
        base   = {a[15:4], 4'h0};
        st     = 0;
        nreq   = 0;
        last_c = -10;
        addr   = a;
        rd_en  = 1'b1;
        inv    = (inv_at == 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (mem_en) begin
                check({tag, " req_rd"}, {15'b0, mem_wr}, 16'h0000);
                check({tag, " req_addr"}, mem_addr, base + 16'(2 * (nreq % 8)));
                if (nreq % 8 != 0) check({tag, " req_slot"}, 16'(c), 16'(last_c + 1));
                last_c = c;
                nreq++;
            end
            if (!stall) break;
            st++;
            next_cycle();
            inv = (c + 1 == inv_at);
        end
        inv = 1'b0;
        check({tag, " stall_cycles"}, 16'(st), 16'(exp_st));
        check({tag, " req_count"}, 16'(nreq), 16'(exp_req));
        check({tag, " rd_data"}, rd_data, exp);
        next_cycle();
        rd_en = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic also_rd,
                            input string tag);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        rd_en = also_rd;
        @(negedge clk);
        check({tag, " mem_en"}, {15'b0, mem_en}, 16'h0001);
        check({tag, " mem_wr"}, {15'b0, mem_wr}, 16'h0001);
        check({tag, " mem_addr"}, mem_addr, a);
        check({tag, " mem_wdata"}, mem_wdata, d);
        check({tag, " stall"}, {15'b0, stall}, 16'h0000);
        check({tag, " rd_data"}, rd_data, 16'h0000);
        next_cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 16'h0246;
        wdata = 16'hFFFF;
        rd_en = 1'b1;
        wr_en = 1'b1;
        inv   = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        check("reset stall", {15'b0, stall}, 16'h0000);
        check("reset mem_en", {15'b0, mem_en}, 16'h0000);
        check("reset mem_wr", {15'b0, mem_wr}, 16'h0000);
        check("reset mem_addr", mem_addr, 16'h0000);
        check("reset mem_wdata", mem_wdata, 16'h0000);
        check("reset rd_data", rd_data, 16'h0000);
        next_cycle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        do_load(16'h0246, 16'hA7E3, 13, 8, -1, "cold");
        do_load(16'h0240, 16'hA7E5, 0, 0, -1, "hit0240");
        do_load(16'h024E, 16'hA7EB, 0, 0, -1, "hit024E");

        do_store(16'h0244, 16'h1234, 1'b0, "st_hit");
        do_load(16'h0244, 16'h1234, 0, 0, -1, "ld_after_st");

        do_load(16'h0440, 16'hA1E5, 13, 8, -1, "conflict");
        do_load(16'h0240, 16'hA7E5, 13, 8, -1, "remiss");
        do_load(16'h0244, 16'h1234, 0, 0, -1, "wt_refill");

        do_store(16'h8000, 16'hBEEF, 1'b1, "st_miss");
        do_load(16'h8000, 16'hBEEF, 13, 8, -1, "ld_8000");

        do_load(16'h0440, 16'hA1E5, 13, 8, -1, "fill0440");
        do_load(16'h0440, 16'hA1E5, 0, 0, -1, "hit0440");
        inv = 1'b1;
        next_cycle();
        inv = 1'b0;
        do_load(16'h0440, 16'hA1E5, 13, 8, -1, "after_inv");

        do_load(16'h0246, 16'hA7E3, 26, 16, 5, "inv_in_fill");
        do_load(16'h0246, 16'hA7E3, 0, 0, -1, "hit_after_refill");

        addr  = 16'h0A00;
        rd_en = 1'b1;
        repeat (6) next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst_mid stall", {15'b0, stall}, 16'h0000);
        check("rst_mid mem_en", {15'b0, mem_en}, 16'h0000);
        check("rst_mid rd_data", rd_data, 16'h0000);
        rd_en = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst mem_en", {15'b0, mem_en}, 16'h0000);
            check("post_rst stall", {15'b0, stall}, 16'h0000);
            next_cycle();
        end
        do_load(16'h0A00, 16'hAFA5, 13, 8, -1, "reload");
        do_load(16'h0246, 16'hA7E3, 13, 8, -1, "rst_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
